// File: rtl/mbist_chan_mux_if.sv
// Channel-side and output-side handshake bundle for the MBIST channel multiplexer.
// The master is the environment (sources plus downstream sink); the slave is the mux.
interface mbist_chan_mux_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
);
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]        data_out;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, out_valid
    );

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, out_valid
    );
endinterface

// File: rtl/mbist_chan_mux.sv
// Registered N:1 channel mux, manual select or round-robin scan; optional beat counter under MBIST_MUX_BEAT_CNT_EN.
// Latency: 1 cycle from accept to out_valid; sustains 1 beat per cycle.
// Backpressure: the selected channel is ready only when the output register is empty or draining.
module mbist_chan_mux #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_CH     = 4,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    mbist_chan_mux_if.slave      bus,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel_req,
    input  logic                 sel_load,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 sel_err
`ifdef MBIST_MUX_BEAT_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [15:0]          beat_cnt
`endif
);

    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      sel_d;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] ch_dat;
    logic [NUM_CH-1:0]     rdy;
    logic                  take;
    logic                  accept;
    logic                  load_ok;
    logic                  load_bad;

    always_comb begin
        take     = !vld_q || bus.out_ready;
        ch_dat   = bus.data_in[sel_q*DATA_WIDTH +: DATA_WIDTH];
        rdy      = '0;
        if (!rst && take) begin
            rdy[sel_q] = 1'b1;
        end
        accept   = !rst && take && bus.in_valid[sel_q];
        load_ok  = sel_load && ({1'b0, sel_req} < CH_LIMIT);
        load_bad = sel_load && !load_ok;

        // An explicit load overrides the scan step; the beat still comes from sel_q.
        sel_d = sel_q;
        if (load_ok) begin
            sel_d = sel_req;
        end else if (mode && accept) begin
            sel_d = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            vld_q <= 1'b0;
            dat_q <= '0;
            err_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            err_q <= load_bad;
            if (accept) begin
                vld_q <= 1'b1;
                dat_q <= ch_dat;
            end else if (bus.out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.data_out  = dat_q;
    assign bus.out_valid = vld_q;
    assign cur_sel       = sel_q;
    assign sel_err       = err_q;

`ifdef MBIST_MUX_BEAT_CNT_EN
    logic [15:0] beat_cnt_q;

    // Clear beats a same-cycle delivery; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            beat_cnt_q <= '0;
        end else if (vld_q && bus.out_ready && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: doc/mbist_chan_mux.md
Name: mbist_chan_mux

Overview:
- Parametrised, registered N:1 channel multiplexer for the MBIST datapath. Generalises the fixed 4:1 combinational selector.
- Collects data beats from NUM_CH source channels over valid/ready handshakes and forwards them through a one-deep output register.
- Channel selection is either manual (software-loaded select) or automatic round-robin scan.
- Sits between per-array BIST pattern/response sources and the shared comparator/response analyser.

Parameters:
- DATA_WIDTH, 8, width of each channel beat and of data_out.
- NUM_CH, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_CH), derived localparam (not overridable); width of the select fields.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_CH  per-channel beat valid.
- in_ready  output  NUM_CH  per-channel ready; at most one bit is high.
- mode  input  1  0 = manual select, 1 = round-robin scan.
- sel_req  input  SEL_W  requested channel for manual load.
- sel_load  input  1  one-cycle strobe that loads sel_req into cur_sel.
- cur_sel  output  SEL_W  currently selected channel.
- sel_err  output  1  one-cycle pulse when a load is rejected.
- data_out  output  DATA_WIDTH  registered output beat.
- out_valid  output  1  data_out holds a valid beat.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset values (rst sampled high at a clock edge): cur_sel=0, out_valid=0, data_out=0, sel_err=0. in_ready is 0 while rst is high. Reset mid-transfer discards any held beat.
- Definitions: take = !out_valid || out_ready. in_ready[cur_sel] = take; all other in_ready bits are 0.
- Accept: in_valid[cur_sel] && in_ready[cur_sel]. On accept, data_out <= selected channel data and out_valid <= 1 at the next edge. Latency is 1 cycle; sustained throughput is 1 beat per cycle.
- Drain: out_valid && out_ready with no accept -> out_valid <= 0. data_out holds its last value.
- Hold: while out_valid && !out_ready, data_out and out_valid are stable and no channel is ready.
- Manual mode (mode=0):
  - sel_load with sel_req < NUM_CH -> cur_sel <= sel_req at the next edge.
  - sel_load with sel_req >= NUM_CH -> cur_sel unchanged; sel_err=1 for exactly one cycle.
  - Out-of-range requests are possible only when NUM_CH is not a power of two.
- Scan mode (mode=1):
  - Each accept advances cur_sel by 1. NUM_CH-1 wraps to 0.
  - No accept -> cur_sel holds. A starved channel stalls the scan; it is not skipped.
- Simultaneous accept and sel_load:
  - The beat is taken from the old cur_sel.
  - A valid sel_load wins over the scan advance.
  - A held beat in the output register is never affected by a select change.
- mode change: takes effect from the next cycle; cur_sel is not altered by the change itself.
- sel_err is registered: it asserts the cycle after the rejected load and clears the following cycle.

Optional Feature:
- Macro: MBIST_MUX_BEAT_CNT_EN.
- Defined:
  - Adds output port beat_cnt [15:0] counting delivered beats (out_valid && out_ready).
  - Reset value 0; saturates at 16'hFFFF with no wrap.
  - Adds input cnt_clr (1 bit); cnt_clr synchronously zeroes the counter and wins over a same-cycle increment.
- Undefined: beat_cnt and cnt_clr ports are absent; no counter logic is generated.

Test Plan:
- Reset, then NUM_CH=4, mode=0, sel_load with sel_req=2, in_valid=4'b0100, data_in ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; data_out=8'hA5 with out_valid=1 exactly one cycle after the accept.
- Backpressure: out_ready=0 for 3 cycles with ch0 valid 8'h11 then 8'h22 -> data_out stays 8'h11 and in_ready=0 throughout; 8'h22 is delivered the cycle after out_ready rises.
- Scan: mode=1, all channels valid with data 8'h10..8'h13, out_ready=1 -> data_out sequence 10,11,12,13,10; cur_sel wraps 3->0.
- NUM_CH=5 build, sel_load with sel_req=3'd6 -> sel_err pulses once, cur_sel unchanged; a following sel_load with sel_req=4 -> cur_sel=4, no sel_err.
- Same cycle: mode=1, accept on ch1 plus sel_load with sel_req=3 -> beat comes from ch1, next cur_sel=3 (not 2). Then rst asserted while out_valid=1 -> out_valid=0, cur_sel=0 the next cycle.
- With MBIST_MUX_BEAT_CNT_EN: 5 delivered beats -> beat_cnt=5; cnt_clr asserted with a delivery in the same cycle -> beat_cnt=0; counter preloaded by force to 16'hFFFF, then a further beat -> remains 16'hFFFF.
